// File: rtl/vga_pkg.sv
// Shared constants, colour field offsets and write-FSM encoding for the
// VGA ping-pong line buffer.
package vga_pkg;

   localparam int PIXEL_DEPTH = 4;
   localparam int LINE_WIDTH  = 1000;
   localparam int ADDR_W      = 10;
   localparam int PIX_W       = 3 * PIXEL_DEPTH;

   localparam int R_LO = 0;
   localparam int R_HI = PIXEL_DEPTH - 1;
   localparam int G_LO = PIXEL_DEPTH;
   localparam int G_HI = 2 * PIXEL_DEPTH - 1;
   localparam int B_LO = 2 * PIXEL_DEPTH;
   localparam int B_HI = 3 * PIXEL_DEPTH - 1;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_WIDTH - 1);

   typedef enum logic {
      WR_FILL = 1'b0,
      WR_FULL = 1'b1
   } wr_state_e;

endpackage

// File: rtl/vga_line_buffer_if.sv
// Valid/ready pixel stream from the frame source into the line buffer.
interface vga_line_buffer_if;
   import vga_pkg::*;

   logic             pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic             pix_ready;

   modport master (output pix_valid, output pix_data, input pix_ready);
   modport slave  (input pix_valid, input pix_data, output pix_ready);

endinterface

// File: rtl/vga_line_ram.sv
// Simple dual-port line store: one write port, one registered read port,
// addressed by {bank, index}.
module vga_line_ram
   import vga_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W:0]   waddr_i,
   input  logic [PIX_W-1:0]  wdata_i,
   input  logic [ADDR_W:0]   raddr_i,
   output logic [PIX_W-1:0]  rdata_o
);

   logic [PIX_W-1:0] mem_q [2**(ADDR_W+1)];
   logic [PIX_W-1:0] rdata_q;

   // NOTE: no reset on the array or its read register, otherwise it cannot map to block RAM.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Ping-pong scanline buffer: fills one bank from the pixel stream while the
// display stage reads the other; banks swap on the display's line strobe.
module vga_line_buffer
   import vga_pkg::*;
(
   input  logic                   clock_50mhz,
   input  logic                   reset,
   input  logic                   flush,
   vga_line_buffer_if.slave       pix_if,
   input  logic                   line_swap,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   output logic [PIXEL_DEPTH-1:0] red,
   output logic [PIXEL_DEPTH-1:0] green,
   output logic [PIXEL_DEPTH-1:0] blue,
   output logic                   line_ready,
   output logic                   underrun
);

   if ((2 ** ADDR_W) < LINE_WIDTH) begin : g_addr_chk
      $error("ADDR_W too small for LINE_WIDTH");
   end

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              fill_bank_q, fill_bank_d;
   logic              pix_ready_q;
   logic              line_ready_q, line_ready_d;
   logic              underrun_q, underrun_d;
   logic              rd_hit_q, rd_hit_d;
   logic              wr_en;
   logic              accept;
   logic [PIX_W-1:0]  ram_rdata;

   assign accept = pix_if.pix_valid & pix_ready_q & ~flush;

   // NOTE: every signal gets a default first so this block cannot infer a latch.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      fill_bank_d  = fill_bank_q;
      underrun_d   = 1'b0;
      wr_en        = 1'b0;

      if (flush) begin
         state_d  = WR_FILL;
         wr_ptr_d = '0;
      end else begin
         unique case (state_q)
            WR_FILL: begin
               if (accept) begin
                  wr_en = 1'b1;
                  if (wr_ptr_q == LAST_IDX) begin
                     if (line_swap) begin
                        fill_bank_d = ~fill_bank_q;
                        wr_ptr_d    = '0;
                     end else begin
                        state_d = WR_FULL;
                     end
                  end else begin
                     wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  end
               end
               // A swap that does not coincide with the last pixel is too early.
               if (line_swap && !(accept && wr_ptr_q == LAST_IDX)) begin
                  underrun_d = 1'b1;
               end
            end
            WR_FULL: begin
               if (line_swap) begin
                  fill_bank_d = ~fill_bank_q;
                  wr_ptr_d    = '0;
                  state_d     = WR_FILL;
               end
            end
            default: state_d = WR_FILL;
         endcase
      end

      line_ready_d = (state_d == WR_FULL);
      rd_hit_d     = rd_en & (rd_addr <= LAST_IDX);
   end

   always_ff @(posedge clock_50mhz or posedge reset) begin
      if (reset) begin
         state_q      <= WR_FILL;
         wr_ptr_q     <= '0;
         fill_bank_q  <= 1'b0;
         pix_ready_q  <= 1'b0;
         line_ready_q <= 1'b0;
         underrun_q   <= 1'b0;
         rd_hit_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_bank_q  <= fill_bank_d;
         pix_ready_q  <= (state_d == WR_FILL);
         line_ready_q <= line_ready_d;
         underrun_q   <= underrun_d;
         rd_hit_q     <= rd_hit_d;
      end
   end

   // Read address uses the pre-swap display bank when a swap lands this cycle.
   vga_line_ram u_ram (
      .clk     (clock_50mhz),
      .we_i    (wr_en),
      .waddr_i ({fill_bank_q, wr_ptr_q}),
      .wdata_i (pix_if.pix_data),
      .raddr_i ({~fill_bank_q, rd_addr}),
      .rdata_o (ram_rdata)
   );

   // Blanking is gated by a reset register so RGB clears immediately on reset
   // while the RAM read register itself stays reset-free.
   assign red   = rd_hit_q ? ram_rdata[R_HI:R_LO] : '0;
   assign green = rd_hit_q ? ram_rdata[G_HI:G_LO] : '0;
   assign blue  = rd_hit_q ? ram_rdata[B_HI:B_LO] : '0;

   assign pix_if.pix_ready = pix_ready_q;
   assign line_ready       = line_ready_q;
   assign underrun         = underrun_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed bench for vga_line_buffer: read data checked through a scoreboard,
// control flags checked inline.
module tb_vga_line_buffer;
   import vga_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush;
   logic                   line_swap;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic [PIXEL_DEPTH-1:0] red, green, blue;
   logic                   line_ready, underrun;

   vga_line_buffer_if pix_if ();

   vga_line_buffer dut (
      .clock_50mhz (clk),
      .reset       (rst),
      .flush       (flush),
      .pix_if      (pix_if.slave),
      .line_swap   (line_swap),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .line_ready  (line_ready),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [PIX_W-1:0] exp_q[$];
   logic             chk_req = 1'b0;
   logic             chk_d1  = 1'b0;

   function automatic logic [PIX_W-1:0] pix(input int line, input int i);
      if (line == 0) return PIX_W'(i);
      return PIX_W'(i * 3 + line * 12'h2A5);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: one expected entry per issued read, compared a cycle later.
   always @(posedge clk) chk_d1 <= chk_req;

   always @(negedge clk) begin
      if (chk_d1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_scoreboard_empty: got 0x%0h expected none", {blue, green, red});
         end else begin
            check("rd_rgb", 32'({blue, green, red}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic en, input int addr, input logic [PIX_W-1:0] exp);
      rd_en   = en;
      rd_addr = ADDR_W'(addr);
      chk_req = 1'b1;
      exp_q.push_back(exp);
      tick();
      rd_en   = 1'b0;
      chk_req = 1'b0;
   endtask

   task automatic swap_pulse();
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
   endtask

   // Streams n pixels with pix_valid held high; optionally swaps on the last accept.
   task automatic stream(input int line, input int first, input int n, input logic swap_last);
      int  sent = 0;
      int  bubbles = 0;
      int  cyc = 0;
      logic r;
      while (sent < n && cyc < n + 50) begin
         pix_if.pix_valid = 1'b1;
         pix_if.pix_data  = pix(line, first + sent);
         line_swap        = swap_last && (sent == n - 1);
         r = pix_if.pix_ready;
         tick();
         if (r) sent++;
         else   bubbles++;
         cyc++;
      end
      pix_if.pix_valid = 1'b0;
      line_swap        = 1'b0;
      check("stream_accepts", sent, n);
      check("stream_bubbles", bubbles, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      line_swap = 1'b0;
      rd_en = 1'b0;
      rd_addr = '0;
      pix_if.pix_valid = 1'b0;
      pix_if.pix_data = '0;
      #1;
      check("rst_rgb", {blue, green, red}, 0);
      check("rst_pix_ready", pix_if.pix_ready, 0);
      check("rst_line_ready", line_ready, 0);
      check("rst_underrun", underrun, 0);
      #21 rst = 1'b0;
      tick();
      check("pix_ready_after_rst", pix_if.pix_ready, 1);

      // Full line A into bank 0.
      stream(0, 0, LINE_WIDTH, 1'b0);
      check("full_line_ready", line_ready, 1);
      check("full_pix_ready", pix_if.pix_ready, 0);

      swap_pulse();
      check("swap_pix_ready", pix_if.pix_ready, 1);
      check("swap_line_ready", line_ready, 0);
      rd(1'b1, 5, 12'h005);
      rd(1'b1, 999, 12'h3E7);
      rd(1'b1, 1000, 12'h000);
      rd(1'b1, 1023, 12'h000);
      rd(1'b0, 5, 12'h000);

      // Early swap after 300 pixels of line B.
      stream(1, 0, 300, 1'b0);
      swap_pulse();
      check("underrun_pulse", underrun, 1);
      check("underrun_line_ready", line_ready, 0);
      tick();
      check("underrun_cleared", underrun, 0);
      rd(1'b1, 5, 12'h005);

      // Resume at 300; swap lands on the last accept.
      stream(1, 300, LINE_WIDTH - 300, 1'b1);
      check("lastswap_underrun", underrun, 0);
      check("lastswap_line_ready", line_ready, 0);
      check("lastswap_pix_ready", pix_if.pix_ready, 1);
      rd(1'b1, 299, pix(1, 299));
      rd(1'b1, 300, pix(1, 300));
      rd(1'b1, 5, pix(1, 5));

      // Line C must start at index 0 of the new fill bank.
      stream(2, 0, LINE_WIDTH, 1'b0);
      check("lineC_line_ready", line_ready, 1);
      swap_pulse();
      rd(1'b1, 0, pix(2, 0));
      rd(1'b1, 999, pix(2, 999));

      // Flush at wr_ptr=500 with a pixel presented.
      stream(3, 0, 500, 1'b0);
      flush = 1'b1;
      pix_if.pix_valid = 1'b1;
      pix_if.pix_data  = 12'hFFF;
      tick();
      flush = 1'b0;
      pix_if.pix_valid = 1'b0;
      check("flush_line_ready", line_ready, 0);
      check("flush_pix_ready", pix_if.pix_ready, 1);
      stream(4, 0, 500, 1'b0);
      check("flush_half_line_ready", line_ready, 0);
      stream(4, 500, 500, 1'b0);
      check("flush_full_line_ready", line_ready, 1);
      swap_pulse();
      rd(1'b1, 0, pix(4, 0));
      rd(1'b1, 500, pix(4, 500));

      // Asynchronous reset mid-fill with a live read on the output.
      stream(6, 0, 200, 1'b0);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(7);
      tick();
      check("pre_rst_rgb", {blue, green, red}, 12'hAA9);
      #2 rst = 1'b1;
      #1;
      check("async_rst_rgb", {blue, green, red}, 0);
      check("async_rst_pix_ready", pix_if.pix_ready, 0);
      check("async_rst_line_ready", line_ready, 0);
      rd_en = 1'b0;
      #2 rst = 1'b0;
      tick();
      check("post_rst_pix_ready", pix_if.pix_ready, 1);
      stream(5, 0, LINE_WIDTH, 1'b0);
      check("post_rst_line_ready", line_ready, 1);
      swap_pulse();
      rd(1'b1, 0, pix(5, 0));
      rd(1'b1, 999, pix(5, 999));

      tick();
      tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
